// File: rtl/sb_mem_arbiter_if.sv
// rtl/sb_mem_arbiter_if.sv - requester-side and memory-side bus bundle for sb_mem_arbiter
// master: the arbiter's view; slave: the requesters/memory environment.
interface sb_mem_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]     s_wvalid;
    logic [64*NUM_PORTS-1:0]  s_waddr;
    logic [64*NUM_PORTS-1:0]  s_wstrb;
    logic [512*NUM_PORTS-1:0] s_wdata;
    logic [NUM_PORTS-1:0]     s_wready;
    logic [NUM_PORTS-1:0]     s_rvalid;
    logic [64*NUM_PORTS-1:0]  s_raddr;
    logic [NUM_PORTS-1:0]     s_rready;
    logic [511:0]             s_rdata;

    logic                     m_wvalid;
    logic [63:0]              m_waddr;
    logic [63:0]              m_wstrb;
    logic [511:0]             m_wdata;
    logic                     m_wready;
    logic                     m_rvalid;
    logic [63:0]              m_raddr;
    logic                     m_rready;
    logic [511:0]             m_rdata;

    modport master (
        input  s_wvalid, s_waddr, s_wstrb, s_wdata, s_rvalid, s_raddr,
        input  m_wready, m_rready, m_rdata,
        output s_wready, s_rready, s_rdata,
        output m_wvalid, m_waddr, m_wstrb, m_wdata, m_rvalid, m_raddr
    );

    modport slave (
        output s_wvalid, s_waddr, s_wstrb, s_wdata, s_rvalid, s_raddr,
        output m_wready, m_rready, m_rdata,
        input  s_wready, s_rready, s_rdata,
        input  m_wvalid, m_waddr, m_wstrb, m_wdata, m_rvalid, m_raddr
    );
endinterface

// File: rtl/sb_mem_arbiter.sv
// rtl/sb_mem_arbiter.sv - round-robin write/read arbiter in front of one axi_writer and one axi_reader
// Optional watchdog and sticky status_timeout: define SB_ARB_WATCHDOG_EN.

module sb_arb_channel #(
    parameter int NUM_PORTS = 2,
    parameter int PW        = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    req_i,
    input  logic [NUM_PORTS*PW-1:0] payload_i,
    input  logic                    done_i,
    output logic                    valid_o,
    output logic [PW-1:0]           payload_o,
    output logic [NUM_PORTS-1:0]    ack_o,
    output logic                    idle_o
);
    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             hold_q, hold_d;
    logic [PW-1:0]    payload_q, payload_d;
    logic [IDX_W-1:0] pick;
    logic             pick_found;
    logic [PW-1:0]    pick_payload;

    // Ports above last_q take precedence over ports at or below it, lowest index first.
    always_comb begin
        pick       = last_q;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!pick_found && req_i[i] && (IDX_W'(i) > last_q)) begin
                pick_found = 1'b1;
                pick       = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!pick_found && req_i[i] && (IDX_W'(i) <= last_q)) begin
                pick_found = 1'b1;
                pick       = IDX_W'(i);
            end
        end
    end

    always_comb begin
        pick_payload = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick == IDX_W'(i)) begin
                pick_payload = payload_i[i*PW +: PW];
            end
        end
    end

    // hold_q forces one idle cycle after completion so the finished requester can drop valid.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        payload_d = payload_q;
        hold_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!hold_q && (|req_i)) begin
                    state_d   = ST_BUSY;
                    grant_d   = pick;
                    last_d    = pick;
                    payload_d = pick_payload;
                end
            end
            ST_BUSY: begin
                if (done_i) begin
                    state_d = ST_IDLE;
                    hold_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ack_o[i] = (state_q == ST_BUSY) && done_i && (grant_q == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_PORTS - 1);
            hold_q    <= 1'b0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = (state_q == ST_BUSY);
    assign payload_o = payload_q;
    assign idle_o    = (state_q == ST_IDLE);
endmodule

module sb_mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int WD_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    sb_mem_arbiter_if.master  bus,
    output logic              status_idle,
    output logic              status_timeout
);
    localparam int WPW = 64 + 64 + 512;

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || WD_CYCLES < 1) begin : g_cfg_check
        $error("sb_mem_arbiter: NUM_PORTS must be 2..8 and WD_CYCLES at least 1");
    end

    logic [NUM_PORTS*WPW-1:0] w_payload;
    logic [WPW-1:0]           w_out;
    logic                     w_idle;
    logic                     r_idle;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wpack
        assign w_payload[i*WPW +: WPW] = {bus.s_wdata[i*512 +: 512],
                                          bus.s_wstrb[i*64 +: 64],
                                          bus.s_waddr[i*64 +: 64]};
    end

    sb_arb_channel #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (WPW)
    ) u_wr (
        .clk       (clk),
        .reset     (reset),
        .req_i     (bus.s_wvalid),
        .payload_i (w_payload),
        .done_i    (bus.m_wready),
        .valid_o   (bus.m_wvalid),
        .payload_o (w_out),
        .ack_o     (bus.s_wready),
        .idle_o    (w_idle)
    );

    assign {bus.m_wdata, bus.m_wstrb, bus.m_waddr} = w_out;

    sb_arb_channel #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (64)
    ) u_rd (
        .clk       (clk),
        .reset     (reset),
        .req_i     (bus.s_rvalid),
        .payload_i (bus.s_raddr),
        .done_i    (bus.m_rready),
        .valid_o   (bus.m_rvalid),
        .payload_o (bus.m_raddr),
        .ack_o     (bus.s_rready),
        .idle_o    (r_idle)
    );

    assign bus.s_rdata = bus.m_rdata;
    assign status_idle = w_idle && r_idle && !(|bus.s_wvalid) && !(|bus.s_rvalid);

`ifdef SB_ARB_WATCHDOG_EN
    localparam int              WD_W     = $clog2(WD_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WD_CYCLES);

    logic [1:0]      ch_busy;
    logic [1:0]      ch_done;
    logic [WD_W-1:0] wd_q [2];
    logic [WD_W-1:0] wd_d [2];
    logic            timeout_q, timeout_d;

    assign ch_busy = {!r_idle, !w_idle};
    assign ch_done = {bus.m_rready, bus.m_wready};

    // Counters saturate at the limit; the flag is sticky until reset and never gates arbitration.
    always_comb begin
        timeout_d = timeout_q;
        for (int c = 0; c < 2; c++) begin
            wd_d[c] = '0;
            if (ch_busy[c] && !ch_done[c]) begin
                wd_d[c] = (wd_q[c] == WD_LIMIT) ? wd_q[c] : wd_q[c] + 1'b1;
            end
            if (wd_d[c] == WD_LIMIT) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                wd_q[c] <= '0;
            end
            timeout_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                wd_q[c] <= wd_d[c];
            end
            timeout_q <= timeout_d;
        end
    end

    assign status_timeout = timeout_q;
`else
    assign status_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_sb_mem_arbiter.sv
// tb/tb_sb_mem_arbiter.sv - directed scoreboard bench for sb_mem_arbiter (NUM_PORTS=2, WD_CYCLES=16)
module tb_sb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic status_idle;
    logic status_timeout;

    always #5 clk = ~clk;

    sb_mem_arbiter_if #(.NUM_PORTS(2)) bus ();

    sb_mem_arbiter #(
        .NUM_PORTS (2),
        .WD_CYCLES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .status_idle    (status_idle),
        .status_timeout (status_timeout)
    );

`ifdef SB_ARB_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    localparam logic [511:0] WD0 = {16{32'hA5A5_0001}};
    localparam logic [511:0] WD1 = {16{32'h5A5A_0002}};

    typedef struct {
        logic [1:0]   mask;
        logic [63:0]  addr;
        logic [63:0]  strb;
        logic [511:0] data;
    } wexp_t;

    typedef struct {
        logic [1:0]   mask;
        logic [63:0]  addr;
        logic [511:0] data;
    } rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];
    wexp_t we;
    rexp_t re;
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rpat(input int g);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(g);
        return {16{w}};
    endfunction

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag, input bit rd);
        int n;
        n = 0;
        @(negedge clk);
        while (((rd ? bus.m_rvalid : bus.m_wvalid) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 512'(n < 20), 512'(1'b1));
    endtask

    // Every completion pulse is matched against the oldest expected grant of its channel.
    always @(negedge clk) begin
        if (bus.s_wready !== 2'b00) begin
            if (wq.size() == 0) begin
                check("w_unexpected_pulse", 512'(bus.s_wready), 512'd0);
            end else begin
                we = wq.pop_front();
                check("w_grant", 512'(bus.s_wready), 512'(we.mask));
                check("w_addr", 512'(bus.m_waddr), 512'(we.addr));
                check("w_strb", 512'(bus.m_wstrb), 512'(we.strb));
                check("w_data", bus.m_wdata, we.data);
            end
        end
        if (bus.s_rready !== 2'b00) begin
            if (rq.size() == 0) begin
                check("r_unexpected_pulse", 512'(bus.s_rready), 512'd0);
            end else begin
                re = rq.pop_front();
                check("r_grant", 512'(bus.s_rready), 512'(re.mask));
                check("r_addr", 512'(bus.m_raddr), 512'(re.addr));
                check("r_data", bus.s_rdata, re.data);
            end
        end
    end

    initial begin
        logic [3:0] exp_v;
        reset        = 1'b1;
        bus.s_wvalid = '0;
        bus.s_waddr  = '0;
        bus.s_wstrb  = '0;
        bus.s_wdata  = '0;
        bus.s_rvalid = '0;
        bus.s_raddr  = '0;
        bus.m_wready = 1'b0;
        bus.m_rready = 1'b0;
        bus.m_rdata  = '0;
        cyc(3);
        @(negedge clk);
        check("rst_m_wvalid", 512'(bus.m_wvalid), 512'd0);
        check("rst_m_rvalid", 512'(bus.m_rvalid), 512'd0);
        check("rst_m_waddr", 512'(bus.m_waddr), 512'd0);
        check("rst_m_wstrb", 512'(bus.m_wstrb), 512'd0);
        check("rst_m_wdata", bus.m_wdata, 512'd0);
        check("rst_m_raddr", 512'(bus.m_raddr), 512'd0);
        check("rst_s_wready", 512'(bus.s_wready), 512'd0);
        check("rst_s_rready", 512'(bus.s_rready), 512'd0);
        check("rst_idle", 512'(status_idle), 512'd1);
        check("rst_timeout", 512'(status_timeout), 512'd0);
        cyc();
        reset = 1'b0;

        // single write, completion three cycles after m_wvalid
        cyc();
        bus.s_wvalid        = 2'b01;
        bus.s_waddr[63:0]   = 64'h1000;
        bus.s_wstrb[63:0]   = 64'hff;
        bus.s_wdata[511:0]  = WD0;
        wq.push_back('{2'b01, 64'h1000, 64'hff, WD0});
        @(negedge clk);
        check("w_lat0_valid", 512'(bus.m_wvalid), 512'd0);
        check("w_lat0_busy_not_idle", 512'(status_idle), 512'd0);
        cyc();
        @(negedge clk);
        check("w_lat1_valid", 512'(bus.m_wvalid), 512'd1);
        check("w_lat1_addr", 512'(bus.m_waddr), 512'h1000);
        for (int i = 1; i <= 2; i++) begin
            cyc();
            bus.s_waddr[63:0] = 64'hdead_0000 + 64'(i);
            @(negedge clk);
            check("w_hold_valid", 512'(bus.m_wvalid), 512'd1);
            check("w_hold_addr", 512'(bus.m_waddr), 512'h1000);
        end
        cyc();
        bus.m_wready = 1'b1;
        cyc();
        bus.m_wready = 1'b0;
        bus.s_wvalid = 2'b00;
        @(negedge clk);
        check("w_done_valid", 512'(bus.m_wvalid), 512'd0);
        check("w_done_ready", 512'(bus.s_wready), 512'd0);

        // two readers contending: grants alternate 0,1,0,1
        cyc();
        bus.s_rvalid         = 2'b11;
        bus.s_raddr[63:0]    = 64'h100;
        bus.s_raddr[127:64]  = 64'h200;
        for (int g = 0; g < 4; g++) begin
            rq.push_back('{(g % 2 == 0) ? 2'b01 : 2'b10, (g % 2 == 0) ? 64'h100 : 64'h200, rpat(g)});
        end
        for (int g = 0; g < 4; g++) begin
            wait_valid("r_rr_wait", 1'b1);
            cyc(2);
            bus.m_rready = 1'b1;
            bus.m_rdata  = rpat(g);
            cyc();
            bus.m_rready = 1'b0;
        end
        bus.s_rvalid = 2'b00;

        // port 0 read and port 1 write granted concurrently
        cyc();
        bus.s_rvalid          = 2'b01;
        bus.s_raddr[63:0]     = 64'h2000;
        bus.s_wvalid          = 2'b10;
        bus.s_waddr[127:64]   = 64'h3008;
        bus.s_wstrb[127:64]   = 64'h0f;
        bus.s_wdata[1023:512] = WD1;
        rq.push_back('{2'b01, 64'h2000, rpat(9)});
        wq.push_back('{2'b10, 64'h3008, 64'h0f, WD1});
        cyc();
        @(negedge clk);
        check("cc_rvalid", 512'(bus.m_rvalid), 512'd1);
        check("cc_wvalid", 512'(bus.m_wvalid), 512'd1);
        check("cc_raddr", 512'(bus.m_raddr), 512'h2000);
        check("cc_waddr", 512'(bus.m_waddr), 512'h3008);
        cyc();
        bus.m_wready = 1'b1;
        bus.m_rready = 1'b1;
        bus.m_rdata  = rpat(9);
        cyc();
        bus.m_wready = 1'b0;
        bus.m_rready = 1'b0;
        bus.s_rvalid = 2'b00;
        bus.s_wvalid = 2'b00;

        // port 1 drops its read request while BUSY
        cyc();
        bus.s_rvalid        = 2'b10;
        bus.s_raddr[127:64] = 64'h4040;
        rq.push_back('{2'b10, 64'h4040, rpat(5)});
        cyc();
        bus.s_rvalid        = 2'b00;
        bus.s_raddr[127:64] = 64'hbeef;
        @(negedge clk);
        check("drop_valid", 512'(bus.m_rvalid), 512'd1);
        cyc();
        @(negedge clk);
        check("drop_hold_valid", 512'(bus.m_rvalid), 512'd1);
        check("drop_hold_addr", 512'(bus.m_raddr), 512'h4040);
        cyc();
        bus.m_rready = 1'b1;
        bus.m_rdata  = rpat(5);
        cyc();
        bus.m_rready = 1'b0;
        cyc();
        bus.m_rready = 1'b1;
        @(negedge clk);
        check("stray_idle_rready", 512'(bus.s_rready), 512'd0);
        check("stray_idle_rvalid", 512'(bus.m_rvalid), 512'd0);
        cyc();
        bus.m_rready = 1'b0;

        // back-to-back writes with m_wready held high: valid rising edges three cycles apart
        cyc();
        bus.s_wvalid        = 2'b11;
        bus.s_waddr[63:0]   = 64'h5000;
        bus.s_waddr[127:64] = 64'h6000;
        wq.push_back('{2'b01, 64'h5000, 64'hff, WD0});
        wq.push_back('{2'b10, 64'h6000, 64'h0f, WD1});
        cyc();
        bus.m_wready = 1'b1;
        exp_v = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("w_spacing_valid", 512'(bus.m_wvalid), 512'(exp_v[3-i]));
            cyc();
            if (i == 0) begin
                bus.s_wvalid = 2'b10;
            end
        end
        bus.s_wvalid = 2'b00;
        bus.m_wready = 1'b0;

        // reset during BUSY abandons the read and restores port 0 priority
        cyc();
        bus.s_rvalid      = 2'b01;
        bus.s_raddr[63:0] = 64'h7000;
        cyc();
        @(negedge clk);
        check("rst_busy_pre", 512'(bus.m_rvalid), 512'd1);
        cyc();
        reset        = 1'b1;
        bus.s_rvalid = 2'b00;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy_rvalid", 512'(bus.m_rvalid), 512'd0);
        check("rst_busy_raddr", 512'(bus.m_raddr), 512'd0);
        cyc();
        bus.m_rready = 1'b1;
        @(negedge clk);
        check("rst_stray_rready", 512'(bus.s_rready), 512'd0);
        cyc();
        bus.m_rready        = 1'b0;
        bus.s_rvalid        = 2'b11;
        bus.s_raddr[63:0]   = 64'h8000;
        bus.s_raddr[127:64] = 64'h9000;
        rq.push_back('{2'b01, 64'h8000, rpat(7)});
        cyc();
        @(negedge clk);
        check("rst_regrant_addr", 512'(bus.m_raddr), 512'h8000);
        cyc();
        bus.m_rready = 1'b1;
        bus.m_rdata  = rpat(7);
        cyc();
        bus.m_rready = 1'b0;
        bus.s_rvalid = 2'b00;

        // watchdog: write completion withheld for 16 BUSY cycles
        cyc();
        @(negedge clk);
        check("wd_pre", 512'(status_timeout), 512'd0);
        cyc();
        bus.s_wvalid      = 2'b01;
        bus.s_waddr[63:0] = 64'hA000;
        wq.push_back('{2'b01, 64'hA000, 64'hff, WD0});
        wait_valid("wd_wait", 1'b0);
        cyc(15);
        @(negedge clk);
        check("wd_below_limit", 512'(status_timeout), 512'd0);
        cyc();
        @(negedge clk);
        check("wd_at_limit", 512'(status_timeout), 512'(WD_ON));
        cyc();
        bus.m_wready = 1'b1;
        cyc();
        bus.m_wready = 1'b0;
        bus.s_wvalid = 2'b00;
        cyc();
        @(negedge clk);
        check("wd_sticky", 512'(status_timeout), 512'(WD_ON));
        check("end_idle", 512'(status_idle), 512'd1);
        check("end_wq_empty", 512'(wq.size()), 512'd0);
        check("end_rq_empty", 512'(rq.size()), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
